// File: rtl/ram_burst_reader_pkg.sv
// ram_rd_pkg: shared widths and FSM state encoding for the RAM burst reader
package ram_rd_pkg;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 10;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_e;
endpackage

// File: rtl/ram_burst_reader_if.sv
// ram_burst_reader_if: control, RAM B-port and output stream signals of the burst reader
//   control: start, base_addr, burst_len -> busy, done
//   ram:     ram_ceb, ram_adb, ram_oce, ram_resetb -> ram_dout
//   stream:  m_valid, m_data, m_last with m_ready back-pressure
//   master = reader side, slave = environment side
interface ram_burst_reader_if;
  logic                           start;
  logic [ram_rd_pkg::ADDR_W-1:0]  base_addr;
  logic [ram_rd_pkg::LEN_W-1:0]   burst_len;
  logic                           busy;
  logic                           done;
  logic                           ram_ceb;
  logic [ram_rd_pkg::ADDR_W-1:0]  ram_adb;
  logic                           ram_oce;
  logic                           ram_resetb;
  logic [ram_rd_pkg::DATA_W-1:0]  ram_dout;
  logic                           m_valid;
  logic                           m_ready;
  logic [ram_rd_pkg::DATA_W-1:0]  m_data;
  logic                           m_last;
  modport master (
    input  start, base_addr, burst_len, ram_dout, m_ready,
    output busy, done, ram_ceb, ram_adb, ram_oce, ram_resetb, m_valid, m_data, m_last
  );
  modport slave (
    output start, base_addr, burst_len, ram_dout, m_ready,
    input  busy, done, ram_ceb, ram_adb, ram_oce, ram_resetb, m_valid, m_data, m_last
  );
endinterface

// File: rtl/ram_burst_reader_fifo.sv
// skid_fifo2: 2-entry FIFO absorbing RAM read latency under stream back-pressure
//   push_i/din_i write, pop_i/dout_o read head, count_o occupancy (0..2)
//   callers never push when full nor pop when empty
module skid_fifo2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [2];
  logic         wr_q, rd_q;
  logic [1:0]   count_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_i) mem_q[wr_q] <= din_i;
      wr_q    <= wr_q ^ push_i;
      rd_q    <= rd_q ^ pop_i;
      count_q <= count_q + 2'(push_i) - 2'(pop_i);
    end
  assign dout_o  = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: fetches a LEN-word burst from a 512x16 SDPB RAM B port onto a valid/ready stream
//   clk, rst_n   clock and asynchronous active-low reset
//   rd (master)  start/base_addr/burst_len in, busy/done out; RAM ceb/adb/oce/resetb out,
//                dout in; stream m_valid/m_data/m_last out, m_ready in
module ram_burst_reader
  import ram_rd_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  ram_burst_reader_if.master rd
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d, issued_q, issued_d;
  logic              inflight_q, tag_q;
  logic              accept, pop, ceb, last_issue;
  logic [1:0]        count;
  logic [DATA_W:0]   head;
  assign accept = state_q == S_IDLE && rd.start;
  assign pop    = count != 2'd0 && rd.m_ready;
  // A word popped this cycle frees a slot before the newly issued word lands,
  // so the credit counts it; this keeps one word per cycle without overflow.
  assign ceb        = state_q == S_READ && 3'(count) + 3'(inflight_q) < 3'd2 + 3'(pop);
  assign last_issue = ceb && issued_q == len_q - LEN_W'(1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = !rd.start ? S_IDLE : rd.burst_len == '0 ? S_FIN : S_READ;
      S_READ:  state_d = last_issue ? S_DRAIN : S_READ;
      S_DRAIN: state_d = pop && head[DATA_W] ? S_FIN : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
    base_d   = accept ? rd.base_addr : base_q;
    len_d    = accept ? rd.burst_len : len_q;
    issued_d = accept ? '0 : issued_q + LEN_W'(ceb);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      tag_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      inflight_q <= ceb;
      tag_q      <= last_issue;
    end
  // The last flag rides alongside the word so it stays aligned through the FIFO.
  skid_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .din_i   ({tag_q, rd.ram_dout}),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (count)
  );
  assign rd.busy       = state_q != S_IDLE || rd.start;
  assign rd.done       = state_q == S_FIN;
  assign rd.ram_ceb    = ceb;
  assign rd.ram_adb    = base_q + issued_q[ADDR_W-1:0];
  assign rd.ram_oce    = 1'b1;
  assign rd.ram_resetb = 1'b0;
  assign rd.m_valid    = count != 2'd0;
  assign rd.m_data     = head[DATA_W-1:0];
  assign rd.m_last     = head[DATA_W];
endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: randomized bursts checked every cycle against a transaction-level model
module tb_ram_burst_reader;
  import ram_rd_pkg::*;
  logic clk, rst_n;
  ram_burst_reader_if bus();
  ram_burst_reader dut (.clk(clk), .rst_n(rst_n), .rd(bus));
  logic [DATA_W-1:0] mem [512];
  int checks = 0, passes = 0, cyc = 0, mode = 0;
  int phase = 0, cur_base = 0, cur_len = 0, issued = 0, beats = 0, acc = 0, fv = -1;
  int busy_total = 0, ceb_total = 0;
  bit prev_stall = 0;
  logic [DATA_W:0] prev_word = '0;
  int data_log[$], adb_log[$], done_log[$];
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) if (bus.ram_ceb) bus.ram_dout <= mem[bus.ram_adb];
  task automatic chk(input bit ok, input string nm, input longint act, input longint exp_v);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
  endtask
  task automatic zero_check(input string tag);
    chk(bus.busy == 0, {tag, "_busy"}, bus.busy, 0);
    chk(bus.done == 0, {tag, "_done"}, bus.done, 0);
    chk(bus.ram_ceb == 0, {tag, "_ceb"}, bus.ram_ceb, 0);
    chk(bus.ram_adb == 0, {tag, "_adb"}, bus.ram_adb, 0);
    chk(bus.m_valid == 0, {tag, "_valid"}, bus.m_valid, 0);
    chk(bus.m_data == 0, {tag, "_data"}, bus.m_data, 0);
    chk(bus.m_last == 0, {tag, "_last"}, bus.m_last, 0);
  endtask
  task automatic compare();
    bit hs;
    hs = bus.m_valid && bus.m_ready;
    chk(bus.busy == (phase != 0 || bus.start), "busy", bus.busy, phase != 0 || bus.start);
    chk(bus.done == (phase == 2), "done", bus.done, phase == 2);
    chk(bus.ram_oce && !bus.ram_resetb, "ties", {bus.ram_oce, bus.ram_resetb}, 2);
    if (phase != 1) chk(!bus.ram_ceb && !bus.m_valid, "quiet", {bus.ram_ceb, bus.m_valid}, 0);
    else begin
      if (bus.ram_ceb) begin
        chk(int'(bus.ram_adb) == (cur_base + issued) % 512, "adb", bus.ram_adb, (cur_base + issued) % 512);
        chk(issued < cur_len, "overissue", issued, cur_len);
        chk(issued - beats - int'(hs) < 2, "credit", issued - beats - int'(hs), 1);
        adb_log.push_back(int'(bus.ram_adb));
        issued++;
        ceb_total++;
      end
      if (bus.m_valid && fv < 0) fv = cyc;
      if (bus.m_valid && prev_stall)
        chk({bus.m_last, bus.m_data} == prev_word, "stable", {bus.m_last, bus.m_data}, prev_word);
      if (hs) begin
        chk(bus.m_data == mem[(cur_base + beats) % 512], "data", bus.m_data, mem[(cur_base + beats) % 512]);
        chk(bus.m_last == (beats == cur_len - 1), "last", bus.m_last, beats == cur_len - 1);
        data_log.push_back(int'(bus.m_data));
        beats++;
      end
    end
    prev_stall = bus.m_valid && !bus.m_ready;
    prev_word  = {bus.m_last, bus.m_data};
    if (bus.busy) busy_total++;
    if (bus.done) done_log.push_back(cyc);
    if (phase == 0 && bus.start) begin
      cur_base = int'(bus.base_addr);
      cur_len  = int'(bus.burst_len);
      issued = 0;
      beats  = 0;
      fv     = -1;
      acc    = cyc + 1;
      prev_stall = 0;
      phase  = cur_len == 0 ? 2 : 1;
    end else if (phase == 2) phase = 0;
    else if (phase == 1 && beats == cur_len) phase = 2;
  endtask
  task automatic step();
    @(negedge clk);
    if (rst_n) compare();
    else begin
      phase = 0;
      prev_stall = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
    bus.m_ready = mode == 0 ? 1'b1 : mode == 1 ? !bus.m_ready : $urandom_range(0, 3) != 0;
  endtask
  task automatic run_burst(input int b, input int l, input int m, input int inj, output int acc_o);
    int k;
    mode = m;
    bus.start = 1;
    bus.base_addr = ADDR_W'(b);
    bus.burst_len = LEN_W'(l);
    step();
    acc_o = acc;
    bus.start = 0;
    bus.base_addr = ADDR_W'($urandom);
    bus.burst_len = LEN_W'($urandom);
    k = 0;
    while (phase != 0 && k < 3000) begin
      if (k == inj) begin
        bus.start = 1;
        bus.base_addr = 9'd99;
        bus.burst_len = 10'd3;
      end
      step();
      bus.start = 0;
      k++;
    end
    chk(k < 3000, "timeout", k, 3000);
  endtask
  initial begin
    int a, n0, a0, d0, b0, c0, k;
    int exp_adb[4];
    rst_n = 0;
    bus.start = 0;
    bus.base_addr = '0;
    bus.burst_len = '0;
    bus.m_ready = 1;
    for (int i = 0; i < 512; i++) mem[i] = DATA_W'(i);
    #3 zero_check("reset");
    @(posedge clk);
    #1 rst_n = 1;
    repeat (2) step();
    n0 = data_log.size();
    d0 = done_log.size();
    run_burst(0, 4, 0, -1, a);
    for (int i = 0; i < 4; i++) chk(data_log[n0 + i] == i, "t1_word", data_log[n0 + i], i);
    chk(fv == a + 2, "t1_first_valid", fv, a + 2);
    chk(done_log.size() == d0 + 1, "t1_done_count", done_log.size() - d0, 1);
    chk(done_log[d0] == a + 6, "t1_done_cycle", done_log[d0], a + 6);
    a0 = adb_log.size();
    n0 = data_log.size();
    run_burst(510, 4, 0, -1, a);
    exp_adb = '{510, 511, 0, 1};
    for (int i = 0; i < 4; i++) begin
      chk(adb_log[a0 + i] == exp_adb[i], "t2_adb", adb_log[a0 + i], exp_adb[i]);
      chk(data_log[n0 + i] == exp_adb[i], "t2_word", data_log[n0 + i], exp_adb[i]);
    end
    for (int i = 0; i < 512; i++) mem[i] = DATA_W'($urandom);
    n0 = data_log.size();
    run_burst($urandom_range(0, 511), 8, 1, -1, a);
    run_burst($urandom_range(0, 511), 8, 2, -1, a);
    chk(data_log.size() == n0 + 16, "t3_beats", data_log.size() - n0, 16);
    d0 = done_log.size();
    b0 = busy_total;
    c0 = ceb_total;
    n0 = data_log.size();
    run_burst(100, 0, 0, -1, a);
    chk(busy_total - b0 == 2, "t4_busy_cycles", busy_total - b0, 2);
    chk(ceb_total == c0, "t4_no_ceb", ceb_total - c0, 0);
    chk(data_log.size() == n0, "t4_no_beats", data_log.size() - n0, 0);
    chk(done_log.size() == d0 + 1, "t4_done_count", done_log.size() - d0, 1);
    d0 = done_log.size();
    n0 = data_log.size();
    run_burst(7, 512, 0, 100, a);
    chk(data_log.size() == n0 + 512, "t5_beats", data_log.size() - n0, 512);
    chk(data_log[data_log.size() - 1] == int'(mem[6]), "t5_last_word", data_log[data_log.size() - 1], mem[6]);
    chk(done_log[d0] == a + 514, "t5_done_cycle", done_log[d0], a + 514);
    mode = 0;
    bus.start = 1;
    bus.base_addr = 9'd300;
    bus.burst_len = 10'd20;
    step();
    bus.start = 0;
    k = 0;
    while (beats < 3 && k < 100) begin
      step();
      k++;
    end
    chk(k < 100, "t6_timeout", k, 100);
    d0 = done_log.size();
    #2 rst_n = 0;
    #1 zero_check("midreset");
    repeat (3) step();
    rst_n = 1;
    n0 = data_log.size();
    run_burst(450, 10, 2, -1, a);
    chk(done_log.size() == d0 + 1, "t6_done_count", done_log.size() - d0, 1);
    chk(data_log.size() == n0 + 10, "t6_beats", data_log.size() - n0, 10);
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 512; i++) mem[i] = DATA_W'($urandom);
      run_burst($urandom_range(0, 511), $urandom_range(0, 40), $urandom_range(0, 2), -1, a);
      repeat ($urandom_range(0, 2)) step();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
